// File: rtl/jk_pkg.sv
// jk_pkg: mode encoding shared by the JK register bank and its users.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_t;

endpackage

// File: rtl/jk_ff_cell.sv
// jk_ff_cell: one rising-edge JK flip-flop with asynchronous active-high reset to RST_BIT.
module jk_ff_cell (
    input  logic C,
    input  logic RESET,
    input  logic RST_BIT,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qb
);

    logic q_q, q_d;

    assign q_d = (J & K) ? ~q_q : J ? 1'b1 : K ? 1'b0 : q_q;

    always_ff @(posedge C or posedge RESET) begin
        if (RESET) q_q <= RST_BIT;
        else       q_q <= q_d;
    end

    assign Q  = q_q;
    assign Qb = ~q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: W-bit JK flip-flop bank acting as JK storage, load register, or up/down counter.
// Define JK_REG_BANK_SAT_EN to make UP/DOWN saturate at their terminal value instead of wrapping.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         C,
    input  logic         RESET,
    input  logic         EN,
    input  logic [1:0]   MODE,
    input  logic [W-1:0] J,
    input  logic [W-1:0] K,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic [W-1:0] Qb,
    output logic         TC
);

    mode_t        mode;
    logic [W-1:0] all1, all0, tog, jc, kc;
    logic         sat;

    assign mode = mode_t'(MODE);
    assign TC   = (mode == MODE_UP) ? &Q : (mode == MODE_DOWN) ? ~|Q : 1'b0;

`ifdef JK_REG_BANK_SAT_EN
    // TC is exactly the wrap condition of the active count direction
    assign sat = TC;
`else
    assign sat = 1'b0;
`endif

    always_comb begin
        all1 = '1;
        all0 = '1;
        for (int i = 1; i < W; i++) begin
            all1[i] = all1[i-1] & Q[i-1];
            all0[i] = all0[i-1] & ~Q[i-1];
        end
        tog = sat ? '0 : (mode == MODE_UP) ? all1 : all0;
        jc  = !EN ? '0 : (mode == MODE_JK) ? J : (mode == MODE_LOAD) ? D  : tog;
        kc  = !EN ? '0 : (mode == MODE_JK) ? K : (mode == MODE_LOAD) ? ~D : tog;
    end

    for (genvar i = 0; i < W; i++) begin : g_cell
        jk_ff_cell u_cell (
            .C       (C),
            .RESET   (RESET),
            .RST_BIT (RST_VAL[i]),
            .J       (jc[i]),
            .K       (kc[i]),
            .Q       (Q[i]),
            .Qb      (Qb[i])
        );
    end

endmodule
